// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Purpose  : Plays a writable table of square-wave notes on a 1-bit output.
//            Each note lasts DUR_CYC clock cycles. A table entry holds the
//            half-period in clock cycles, and a zero entry is a rest.
//            Playback can run once or loop, and can be aborted with stop.
// Ports    : clk, reset     - clock and synchronous active-high reset
//            start, stop    - playback control (stop wins over start)
//            loop_mode      - 1 = wrap to note 0 after the last note
//            len            - number of notes to play, clamped to DEPTH
//            wr_en/addr/data- note-table write port
//            signalout      - square-wave output
//            busy           - high while playing
//            note_idx       - index of the sounding note (held in idle)
//            done           - one-cycle pulse at the end of a one-shot run
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
  parameter int CLK_HZ  = 50000000,
  parameter int NOTE_MS = 1000,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter int HP_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_mode,
  input  logic [IDX_W:0]   len,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [HP_W-1:0]  wr_data,
  output logic             signalout,
  output logic             busy,
  output logic [IDX_W-1:0] note_idx,
  output logic             done
);

  localparam int DUR_CYC = (CLK_HZ / 1000) * NOTE_MS;
  localparam int DUR_W   = (DUR_CYC > 1) ? $clog2(DUR_CYC) : 1;
  // Table is sized to the full index range so any index is in bounds;
  // entries at or above DEPTH are never written and stay zero.
  localparam int TBL_N   = 1 << IDX_W;

  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYC - 1);
  localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           r_state;
  logic [HP_W-1:0]  r_table [TBL_N];
  logic [IDX_W:0]   r_len_lat;
  logic [HP_W-1:0]  r_hp_lat;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [HP_W-1:0]  r_half_cnt;

  logic [IDX_W:0]   w_next_idx;
  logic             w_more_notes;
  logic             w_start_ok;
  logic [IDX_W:0]   w_len_clamp;

  // note_idx doubles as the playback index register.
  assign w_next_idx   = {1'b0, note_idx} + 1'b1;
  assign w_more_notes = (w_next_idx < r_len_lat);
  assign w_start_ok   = start && !stop && (len != '0);
  assign w_len_clamp  = (len > DEPTH_L) ? DEPTH_L : len;

  // Note table. Reads elsewhere see the pre-edge contents, so a write on
  // the same edge as a note load affects only later loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TBL_N; i++) begin
        r_table[i] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      signalout  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      note_idx   <= '0;
      r_len_lat  <= '0;
      r_hp_lat   <= '0;
      r_dur_cnt  <= '0;
      r_half_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state    <= PLAY;
            busy       <= 1'b1;
            r_len_lat  <= w_len_clamp;
            note_idx   <= '0;
            r_hp_lat   <= r_table[0];
            r_dur_cnt  <= '0;
            r_half_cnt <= '0;
            signalout  <= 1'b0;
          end
        end
        PLAY: begin
          if (stop) begin
            r_state   <= IDLE;
            busy      <= 1'b0;
            signalout <= 1'b0;
          end else if (r_dur_cnt == DUR_LAST) begin
            // Note boundary replaces the tone step on this edge.
            r_dur_cnt  <= '0;
            r_half_cnt <= '0;
            signalout  <= 1'b0;
            if (w_more_notes) begin
              note_idx <= w_next_idx[IDX_W-1:0];
              r_hp_lat <= r_table[w_next_idx[IDX_W-1:0]];
            end else if (loop_mode) begin
              note_idx <= '0;
              r_hp_lat <= r_table[0];
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            r_dur_cnt <= r_dur_cnt + 1'b1;
            if (r_hp_lat == '0) begin
              signalout <= 1'b0;
            end else if (r_half_cnt == r_hp_lat - 1'b1) begin
              signalout  <= ~signalout;
              r_half_cnt <= '0;
            end else begin
              r_half_cnt <= r_half_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_sequencer
// Purpose  : Directed self-checking bench for tone_sequencer. A time-based
//            model (signal derived from cycles since note start) is compared
//            with the DUT after every clock edge, plus literal timeline checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int NOTE_MS = 10;
  localparam int DEPTH   = 4;
  localparam int IDX_W   = 3;
  localparam int HP_W    = 8;
  localparam int DUR     = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             loop_mode;
  logic [IDX_W:0]   len;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [HP_W-1:0]  wr_data;
  logic             signalout;
  logic             busy;
  logic [IDX_W-1:0] note_idx;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0     = 0;

  // Model state: table contents, whether playing, cycles since note start.
  int m_tbl [DEPTH];
  bit m_play;
  int m_t;
  int m_idx;
  int m_hp;
  int m_len;
  bit m_done;
  bit m_sig;

  tone_sequencer #(
    .CLK_HZ (CLK_HZ),
    .NOTE_MS(NOTE_MS),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .HP_W   (HP_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_mode(loop_mode),
    .len      (len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .signalout(signalout),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at E0+%0d (cycle %0d): got %0d, expected %0d",
               name, cyc - e0, cyc, act, exp);
    end
  endtask

  // Advance the model by one edge using the inputs the DUT samples.
  task automatic model_step();
    m_done = 1'b0;
    if (reset) begin
      m_play = 1'b0;
      m_t    = 0;
      m_idx  = 0;
      m_hp   = 0;
      m_len  = 0;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    end else begin
      if (m_play) begin
        if (stop) begin
          m_play = 1'b0;
        end else if (m_t == DUR - 1) begin
          if (m_idx + 1 < m_len) begin
            m_idx = m_idx + 1;
            m_hp  = m_tbl[m_idx];
            m_t   = 0;
          end else if (loop_mode) begin
            m_idx = 0;
            m_hp  = m_tbl[0];
            m_t   = 0;
          end else begin
            m_play = 1'b0;
            m_done = 1'b1;
          end
        end else begin
          m_t = m_t + 1;
        end
      end else if (start && !stop && len != '0) begin
        m_play = 1'b1;
        m_len  = (int'(len) > DEPTH) ? DEPTH : int'(len);
        m_idx  = 0;
        m_hp   = m_tbl[0];
        m_t    = 0;
      end
      if (wr_en && int'(wr_addr) < DEPTH) m_tbl[int'(wr_addr)] = int'(wr_data);
    end
    // Square wave: level flips every m_hp cycles, starting low at note start.
    m_sig = (m_play && m_hp != 0) ? (((m_t / m_hp) % 2) == 1) : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("signalout", 32'(signalout), 32'(m_sig));
    chk("busy",      32'(busy),      32'(m_play));
    chk("note_idx",  32'(note_idx),  m_idx);
    chk("done",      32'(done),      32'(m_done));
  endtask

  task automatic go(input int n);
    while (cyc < e0 + n) tick();
  endtask

  task automatic do_start(input int l, input bit lp);
    start     = 1'b1;
    len       = (IDX_W + 1)'(l);
    loop_mode = lp;
    tick();
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(a);
    wr_data = HP_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
    len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sig",  32'(signalout), 0);
    chk("rst_idx",  32'(note_idx), 0);
    reset = 1'b0;
    tick();

    wr(0, 2); wr(1, 3); wr(2, 0); wr(3, 1);

    // One-shot, len 3
    do_start(3, 1'b0);
    chk("os_busy_e0", 32'(busy), 1);
    go(1);  chk("os_sig_e1",  32'(signalout), 0);
    go(2);  chk("os_sig_e2",  32'(signalout), 1);
    go(4);  chk("os_sig_e4",  32'(signalout), 0);
    go(10); chk("os_idx_e10", 32'(note_idx), 1); chk("os_sig_e10", 32'(signalout), 0);
    go(12); chk("os_sig_e12", 32'(signalout), 0);
    go(13); chk("os_sig_e13", 32'(signalout), 1);
    go(25); chk("os_rest_e25", 32'(signalout), 0);
    go(30); chk("os_done_e30", 32'(done), 1); chk("os_busy_e30", 32'(busy), 0);
    go(31); chk("os_done_e31", 32'(done), 0);
    go(33);

    // Loop mode, len 2, loop cleared for edge E0+25
    do_start(2, 1'b1);
    go(10); chk("lp_idx_e10", 32'(note_idx), 1);
    go(20); chk("lp_idx_e20", 32'(note_idx), 0); chk("lp_done_e20", 32'(done), 0);
    go(24); loop_mode = 1'b0;
    go(30); chk("lp_idx_e30", 32'(note_idx), 1);
    go(39); chk("lp_busy_e39", 32'(busy), 1);
    go(40); chk("lp_done_e40", 32'(done), 1);
    go(42);

    // Stop at E0+14
    do_start(3, 1'b0);
    go(13); stop = 1'b1;
    go(14); stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_sig",  32'(signalout), 0);
    chk("stop_idx_hold", 32'(note_idx), 1);
    go(35);

    // Start and stop together
    start = 1'b1; stop = 1'b1; len = 4'd3;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_idle", 32'(busy), 0);
    tick();

    // Start while busy is ignored
    do_start(3, 1'b0);
    go(5); start = 1'b1; len = 4'd1;
    tick(); start = 1'b0;
    go(10); chk("sb_idx_e10", 32'(note_idx), 1);
    go(30); chk("sb_done_e30", 32'(done), 1);
    go(32);

    // len = 0 ignored
    start = 1'b1; len = '0;
    tick(); start = 1'b0;
    chk("len0_idle", 32'(busy), 0);
    tick();

    // len = 7 clamped to 4
    do_start(7, 1'b0);
    go(30); chk("clamp_idx_e30", 32'(note_idx), 3);
    go(31); chk("clamp_sig_e31", 32'(signalout), 1);
    go(32); chk("clamp_sig_e32", 32'(signalout), 0);
    go(39); chk("clamp_busy_e39", 32'(busy), 1);
    go(40); chk("clamp_done_e40", 32'(done), 1);
    go(41);

    // Out-of-range write ignored
    wr(5, 9);
    do_start(2, 1'b0);
    go(12); chk("oor_sig_e12", 32'(signalout), 0);
    go(13); chk("oor_sig_e13", 32'(signalout), 1);
    go(21);

    // Write table[1] = 4 during note 0
    do_start(2, 1'b0);
    go(4); wr(1, 4);
    go(13); chk("wdp_sig_e13", 32'(signalout), 0);
    go(14); chk("wdp_sig_e14", 32'(signalout), 1);
    go(20); chk("wdp_done_e20", 32'(done), 1);

    // Write to the sounding note, then restart in the done cycle
    do_start(1, 1'b0);
    go(4); wr(0, 5);
    go(6); chk("wsn_sig_e6", 32'(signalout), 1);
    go(8); chk("wsn_sig_e8", 32'(signalout), 0);
    go(10); chk("wsn_done_e10", 32'(done), 1);
    start = 1'b1; len = 4'd1;
    tick(); start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    e0 = cyc;
    go(5); chk("restart_sig_e5", 32'(signalout), 1);
    go(11);

    // Reset mid-play clears the table
    do_start(4, 1'b1);
    go(5); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rmp_busy", 32'(busy), 0);
    chk("rmp_sig",  32'(signalout), 0);
    chk("rmp_idx",  32'(note_idx), 0);
    chk("rmp_done", 32'(done), 0);
    tick();
    do_start(4, 1'b0);
    go(2);  chk("rmp_silent_e2", 32'(signalout), 0);
    go(15); chk("rmp_silent_e15", 32'(signalout), 0);
    go(40); chk("rmp_done_e40", 32'(done), 1);
    go(42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
